// File: rtl/saturating_accumulator.sv
// saturating_accumulator
//   Saturating integrator for the cell-controller feedback datapath. Sums a
//   signed sample stream into an AWIDTH accumulator that clamps at its limits
//   (never wraps), then presents the value saturation-reduced to OWIDTH one
//   cycle later with a single-cycle valid strobe.
//
//   Build option: define SAT_ACCUM_LEAK_EN for a leaky integrator
//   (acc - (acc >>> LEAK_SHIFT) + inData). Without it the block is a pure
//   integrator and LEAK_SHIFT has no effect.
//
//   Legal parameterisation: AWIDTH >= IWIDTH, AWIDTH >= OWIDTH, LEAK_SHIFT >= 0.
module saturating_accumulator #(
    parameter int IWIDTH     = 16,
    parameter int AWIDTH     = 24,
    parameter int OWIDTH     = 16,
    parameter int LEAK_SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic              inValid,
    input  logic [IWIDTH-1:0] inData,
    output logic              outValid,
    output logic [OWIDTH-1:0] outData,
    output logic              outSat,
    output logic              accSat,
    output logic [15:0]       satCount
);

    // One guard bit is enough for acc + sample; the leak path subtracts a
    // further term, so it carries a second guard bit.
`ifdef SAT_ACCUM_LEAK_EN
    localparam int SW = AWIDTH + 2;
`else
    localparam int SW = AWIDTH + 1;
`endif

    // Elaborates only for an illegal parameter set, making it visible in
    // the hierarchy of any elaboration report.
    if ((AWIDTH < IWIDTH) || (AWIDTH < OWIDTH) || (LEAK_SHIFT < 0)) begin : g_illegal_params
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [AWIDTH-1:0] acc_q,       acc_d;
    logic                     acc_sat_q,   acc_sat_d;
    logic [15:0]              sat_count_q, sat_count_d;
    logic                     pend_q,      pend_d;
    logic                     out_valid_q, out_valid_d;
    logic [OWIDTH-1:0]        out_data_q,  out_data_d;
    logic                     out_sat_q,   out_sat_d;

    // ------------------------------------------------------------------
    // Stage-1 arithmetic
    // ------------------------------------------------------------------
    logic               accept;
    logic signed [SW-1:0] acc_ext;
    logic signed [SW-1:0] in_ext;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] acc_lim_max;
    logic signed [SW-1:0] acc_lim_min;
    logic               pos_clamp;
    logic               neg_clamp;
    logic signed [AWIDTH-1:0] acc_next;

    assign accept = inValid & enable & ~clear;

    // Extended sum and accumulator clamp; the wide sum makes overflow a
    // simple signed compare against the accumulator limits.
    always_comb begin
        acc_ext     = SW'(acc_q);
        in_ext      = SW'($signed(inData));
        acc_lim_max = SW'($signed({1'b0, {(AWIDTH-1){1'b1}}}));
        acc_lim_min = SW'($signed({1'b1, {(AWIDTH-1){1'b0}}}));
`ifdef SAT_ACCUM_LEAK_EN
        sum         = acc_ext - (acc_ext >>> LEAK_SHIFT) + in_ext;
`else
        sum         = acc_ext + in_ext;
`endif
        pos_clamp   = (sum > acc_lim_max);
        neg_clamp   = (sum < acc_lim_min);
        if (pos_clamp) begin
            acc_next = acc_lim_max[AWIDTH-1:0];
        end else if (neg_clamp) begin
            acc_next = acc_lim_min[AWIDTH-1:0];
        end else begin
            acc_next = sum[AWIDTH-1:0];
        end
    end

    // Stage-1 next state: clear wins over a same-cycle sample.
    always_comb begin
        acc_d       = acc_q;
        acc_sat_d   = acc_sat_q;
        sat_count_d = sat_count_q;
        pend_d      = accept;
        if (clear) begin
            acc_d       = '0;
            acc_sat_d   = 1'b0;
            sat_count_d = '0;
        end else if (accept) begin
            acc_d = acc_next;
            if (pos_clamp || neg_clamp) begin
                acc_sat_d = 1'b1;
                if (sat_count_q != 16'hFFFF) begin
                    sat_count_d = sat_count_q + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage-2 output reduction
    // ------------------------------------------------------------------
    logic signed [AWIDTH-1:0] out_lim_max;
    logic signed [AWIDTH-1:0] out_lim_min;
    logic                     out_pos_clamp;
    logic                     out_neg_clamp;

    // Output clamp of the accumulator; data/sat hold between strobes. A
    // pending strobe still issues on a clear edge, showing the pre-clear acc.
    always_comb begin
        out_lim_max   = AWIDTH'($signed({1'b0, {(OWIDTH-1){1'b1}}}));
        out_lim_min   = AWIDTH'($signed({1'b1, {(OWIDTH-1){1'b0}}}));
        out_pos_clamp = (acc_q > out_lim_max);
        out_neg_clamp = (acc_q < out_lim_min);
        out_valid_d   = pend_q;
        out_data_d    = out_data_q;
        out_sat_d     = out_sat_q;
        if (pend_q) begin
            out_sat_d = out_pos_clamp | out_neg_clamp;
            if (out_pos_clamp) begin
                out_data_d = out_lim_max[OWIDTH-1:0];
            end else if (out_neg_clamp) begin
                out_data_d = out_lim_min[OWIDTH-1:0];
            end else begin
                out_data_d = acc_q[OWIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // All pipeline state; reset drops any in-flight strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            acc_sat_q   <= 1'b0;
            sat_count_q <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_sat_q   <= acc_sat_d;
            sat_count_q <= sat_count_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign outValid = out_valid_q;
    assign outData  = out_data_q;
    assign outSat   = out_sat_q;
    assign accSat   = acc_sat_q;
    assign satCount = sat_count_q;

endmodule

// File: tb/tb_saturating_accumulator.sv
// tb_saturating_accumulator
//   Directed-vector scoreboard bench. Stimulus pushes expected outputs
//   (data, sat flag, arrival cycle) into a queue; a monitor pops and compares
//   whenever an output strobe is due or appears.
module tb_saturating_accumulator;

    localparam int IW = 16;
    localparam int AW = 24;
    localparam int OW = 16;
    localparam int LS = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          enable = 1'b1;
    logic          inValid = 1'b0;
    logic [IW-1:0] inData = '0;
    logic          outValid;
    logic [OW-1:0] outData;
    logic          outSat;
    logic          accSat;
    logic [15:0]   satCount;

    saturating_accumulator #(
        .IWIDTH(IW), .AWIDTH(AW), .OWIDTH(OW), .LEAK_SHIFT(LS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable),
        .inValid(inValid), .inData(inData), .outValid(outValid),
        .outData(outData), .outSat(outSat), .accSat(accSat),
        .satCount(satCount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] d;
        logic          s;
        int            c;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    longint m_acc = 0;
    bit     m_sat = 0;
    int     m_cnt = 0;
    longint AMAX  = (longint'(1) <<< (AW-1)) - 1;
    longint AMIN  = -(longint'(1) <<< (AW-1));
    longint OMAX  = (longint'(1) <<< (OW-1)) - 1;
    longint OMIN  = -(longint'(1) <<< (OW-1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model_step(input longint x);
        longint s;
        longint o;
        exp_t   e;
`ifdef SAT_ACCUM_LEAK_EN
        s = m_acc - (m_acc >>> LS) + x;
`else
        s = m_acc + x;
`endif
        if (s > AMAX) begin
            m_acc = AMAX; m_sat = 1; if (m_cnt != 65535) m_cnt++;
        end else if (s < AMIN) begin
            m_acc = AMIN; m_sat = 1; if (m_cnt != 65535) m_cnt++;
        end else begin
            m_acc = s;
        end
        e.s = 1'b1;
        if (m_acc > OMAX)      o = OMAX;
        else if (m_acc < OMIN) o = OMIN;
        else begin o = m_acc; e.s = 1'b0; end
        e.d = o[OW-1:0];
        e.c = 0;
        return e;
    endfunction

    task automatic send(input int v);
        exp_t e;
        @(negedge clk);
        clear = 1'b0; enable = 1'b1; inValid = 1'b1;
        inData = IW'(v);
        e = model_step(longint'(v));
        e.c = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clear = 1'b0; enable = 1'b1; inValid = 1'b0;
        end
    endtask

    task automatic do_clear(input bit with_sample, input int v);
        @(negedge clk);
        clear = 1'b1; enable = 1'b1; inValid = with_sample;
        inData = IW'(v);
        m_acc = 0; m_sat = 0; m_cnt = 0;
    endtask

    // Monitor: compare strobes against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (sb.size() > 0 && sb[0].c == cyc) begin
                    e = sb.pop_front();
                    n_vec++;
                    if (outValid !== 1'b1 || outData !== e.d || outSat !== e.s) begin
                        n_err++;
                        $display("FAIL out@%0d: got v=%b d=%h s=%b expected v=1 d=%h s=%b",
                                 cyc, outValid, outData, outSat, e.d, e.s);
                    end
                end else if (outValid !== 1'b0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out@%0d: got outValid=%b expected 0", cyc, outValid);
                end
            end
        end
    end

    initial begin
        // Reset and idle
        idle(3);
        rst_n = 1'b1;
        idle(20);
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_outData",  32'(outData),  32'd0);
        chk("rst_outSat",   32'(outSat),   32'd0);
        chk("rst_accSat",   32'(accSat),   32'd0);
        chk("rst_satCount", 32'(satCount), 32'd0);

        // Basic sum: 1000, 700, 750
        send(1000); send(-300); send(50);
        idle(4);
        chk("basic_accSat", 32'(accSat), 32'd0);

        // Clear with same-cycle sample; pending -300 output still shows 700
        do_clear(1'b0, 0);
        send(1000); send(-300);
        do_clear(1'b1, 5);
        send(0);
        idle(4);

        // enable low with inValid: no strobe, acc holds
        @(negedge clk);
        enable = 1'b0; inValid = 1'b1; inData = IW'(123);
        idle(3);
        send(0);
        idle(4);

        // Positive clamp
        do_clear(1'b0, 0);
        repeat (256) send(32767);
        idle(4);
`ifndef SAT_ACCUM_LEAK_EN
        chk("pos256_accSat_lit", 32'(accSat), 32'd0);
`endif
        chk("pos256_accSat", 32'(accSat), 32'(m_sat));
        send(32767);
        idle(4);
`ifndef SAT_ACCUM_LEAK_EN
        chk("pos257_accSat_lit",   32'(accSat),   32'd1);
        chk("pos257_satCount_lit", 32'(satCount), 32'd1);
`endif
        chk("pos257_satCount", 32'(satCount), 32'(m_cnt));
        chk("pos257_outData",  32'(outData),  32'h7FFF);

        // Negative limit: exact hit is not a clamp
        do_clear(1'b0, 0);
        repeat (256) send(-32768);
        idle(4);
`ifndef SAT_ACCUM_LEAK_EN
        chk("neg256_accSat_lit", 32'(accSat), 32'd0);
`endif
        chk("neg256_accSat", 32'(accSat), 32'(m_sat));
        send(-32768);
        idle(4);
`ifndef SAT_ACCUM_LEAK_EN
        chk("neg257_accSat_lit",   32'(accSat),   32'd1);
        chk("neg257_satCount_lit", 32'(satCount), 32'd1);
`endif
        chk("neg257_satCount", 32'(satCount), 32'(m_cnt));
        chk("neg257_outData",  32'(outData),  32'h8000);

        // Clear wipes flags and counter
        do_clear(1'b0, 0);
        idle(2);
        chk("clr_accSat",   32'(accSat),   32'd0);
        chk("clr_satCount", 32'(satCount), 32'd0);

`ifdef SAT_ACCUM_LEAK_EN
        // Leak: 25600 -> 25500; -256 -> -255 (floor shift)
        send(25600); send(0);
        idle(3);
        chk("leak_pos", 32'(outData), 32'(16'd25500));
        do_clear(1'b0, 0);
        send(-256); send(0);
        idle(3);
        chk("leak_neg", 32'(outData), 32'(16'hFF01));
`endif

        // Reset mid-operation: in-flight strobe is dropped
        send(7);
        @(negedge clk);
        inValid = 1'b0;
        rst_n = 1'b0;
        void'(sb.pop_back());
        m_acc = 0; m_sat = 0; m_cnt = 0;
        #1;
        chk("midrst_outValid", 32'(outValid), 32'd0);
        chk("midrst_outData",  32'(outData),  32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(3);
        send(-5);
        idle(4);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/saturating_accumulator.md
Name: saturating_accumulator

Overview:
- Saturating integrator: the counterpart of the saturating subtractor. It sums a signed sample stream into a wide accumulator and clamps at the accumulator limits instead of wrapping.
- The accumulated value is saturation-reduced to the output width and presented with a valid strobe.
- Used in the cell-controller feedback datapath: it rebuilds integrated position/correction values from the difference streams.

Parameters:
- IWIDTH, 16, input sample width (signed two's complement).
- AWIDTH, 24, accumulator width (signed); must satisfy AWIDTH >= IWIDTH and AWIDTH >= OWIDTH.
- OWIDTH, 16, output width (signed).
- LEAK_SHIFT, 8, leak divisor exponent; used only when SAT_ACCUM_LEAK_EN is defined.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of accumulator, flags and counter.
- enable  in  1  when low, samples are ignored and the accumulator holds.
- inValid  in  1  inData is valid this cycle.
- inData  in  IWIDTH  signed input sample.
- outValid  out  1  one-cycle strobe; outData/outSat are valid.
- outData  out  OWIDTH  accumulator value, saturation-reduced to OWIDTH.
- outSat  out  1  outData was clamped for this output (per sample, not sticky).
- accSat  out  1  sticky: the accumulator has clamped since the last clear/reset.
- satCount  out  16  count of clamped accumulations; stops at 0xFFFF.

Behaviour:
- Reset (rst_n low, asynchronous): acc=0, outValid=0, outData=0, outSat=0, accSat=0, satCount=0.
- Stage 1, on the clk edge where inValid & enable & !clear:
  - sum = signext(acc, AWIDTH+1) + signext(inData, AWIDTH+1).
  - If sum > 2^(AWIDTH-1)-1, acc takes that maximum. If sum < -2^(AWIDTH-1), acc takes that minimum. Otherwise acc = sum[AWIDTH-1:0].
  - On a clamp: accSat set to 1, and satCount incremented unless it is already 0xFFFF.
  - An exact hit on a limit is not a clamp.
- Stage 2, the edge after a stage-1 update:
  - outValid=1 for exactly one cycle.
  - outData = acc clamped to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1]; outSat=1 iff that clamp applied.
  - outData and outSat hold their values between strobes.
- Latency: a sample accepted at edge n appears at outValid at edge n+1, i.e. 2 cycles from inValid high to outValid high. Throughput is one sample per cycle.
- clear has priority over inValid in the same cycle: acc=0, accSat=0, satCount=0, and that sample is discarded.
  - A stage-2 output from a sample accepted on the previous edge still issues, showing the pre-clear value.
- enable low or inValid low: no stage-1 update and no stage-2 strobe from that cycle.
- Reset mid-operation: any in-flight output is dropped and outValid=0 immediately.
- No internal wrap-around is ever permitted; every result is either exact or clamped.

Optional Feature:
- SAT_ACCUM_LEAK_EN defined: leaky integrator. On each accepted sample, sum = acc - (acc >>> LEAK_SHIFT) + inData, computed in AWIDTH+2 bits, then the same clamping rules as above. The shift is arithmetic, so it floors toward -inf.
- SAT_ACCUM_LEAK_EN undefined: pure integrator; LEAK_SHIFT is ignored and no leak logic is generated.

Test Plan:
- Reset/idle: rst_n low then high, no inValid for 20 cycles -> all outputs 0, outValid never asserted.
- Basic sum: inValid with 1000, -300, 50 on consecutive cycles -> outData 1000, 700, 750 on consecutive cycles, first strobe 2 cycles after the first inValid, outSat=0, accSat=0.
- Positive clamp: 257 consecutive samples of 0x7FFF.
  - outSat=1 from the 2nd output onward (65534 > 32767), outData=0x7FFF.
  - After the 256th sample acc=8388352; the 257th clamps acc to 0x7FFFFF, so accSat=1 and satCount=1.
- Negative limit: 256 samples of -32768 -> acc=-8388608 exactly, accSat=0. A 257th sample -> acc stays -8388608, accSat=1, satCount=1, outData=0x8000.
- Clear/enable interaction: clear and inValid (value 5) together with acc=700 -> acc=0 with the sample discarded. enable=0 with inValid -> no outValid and acc unchanged.
- Leak (macro defined, LEAK_SHIFT=8): acc=25600, sample 0 -> acc=25500. acc=-256, sample 0 -> acc=-255.
